mcyc_sequencer: RTL
===================

MCYC_SEQUENCER -- requirements
Module: mcyc_sequencer

Interface
REQ-001 Parameter NUM_UNITS, default 4, number of multi-cycle execution units (multiplier/divider class) with start/busy handshakes.
REQ-002 Parameter TIMEOUT_W, default 6, width of the busy-wait watchdog counter.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cls  input  3  instruction class from the decoder; held stable from T2 until the instruction completes.
REQ-006 cond_ok  input  1  branch condition, valid in T3.
REQ-007 unit_sel  input  max(1,$clog2(NUM_UNITS))  unit targeted by a CLS_UNIT instruction.
REQ-008 unit_busy  input  NUM_UNITS  per-unit busy flags.
REQ-009 irq  input  1  interrupt request, level; present only with MCYC_IRQ_EN.
REQ-010 state  output  3  current state.
REQ-011 fetch_en  output  1  instruction fetch strobe.
REQ-012 pc_inc  output  1  PC+4 write strobe.
REQ-013 unit_start  output  NUM_UNITS  one-cycle start pulse per unit.
REQ-014 stall  output  1  waiting on a busy unit.
REQ-015 exception  output  1  one-cycle exception strobe; qualifies exc_code.
REQ-016 exc_code  output  2  0 INT, 1 TRAP, 2 ILLEGAL, 3 TIMEOUT.
REQ-017 instr_done  output  1  one-cycle pulse on the last cycle of each instruction.

Function
REQ-018 State encoding: T0=000, T1=001, T2=011, T3=010, T4=110, T5=111, TI=100. Any other value goes to T1.
REQ-019 Transitions T0->T1, T1->T2 and T2->T3 are unconditional.
REQ-020 In T1 assert fetch_en. In T2 assert pc_inc. Both are combinational decodes of state.
REQ-021 Class codes: 0 SHORT, 1 ALU, 2 LOAD, 3 BRANCH, 4 UNIT, 5 TRAP, 6/7 reserved.
REQ-022 SHORT: T3->T1.
REQ-023 ALU: T3->T4->T1.
REQ-024 LOAD: T3->T4->T5->T1.
REQ-025 BRANCH: cond_ok=0 in T3 -> T1; cond_ok=1 -> T4->T5->T1.
REQ-026 UNIT, T3: unit_start[unit_sel] is high for exactly one cycle and all other bits are low; then T4.
REQ-027 UNIT, T4: while unit_busy[unit_sel]=1, remain in T4 with stall=1 and the watchdog incrementing. When it drops to 0, go to T1.
REQ-028 UNIT timeout: if the watchdog equals 2^TIMEOUT_W-1 and busy is still 1, assert exception with exc_code=3 and go to T1; the watchdog clears. If busy drops on that same cycle, normal completion wins and no exception is raised.
REQ-029 TRAP: exception with exc_code=1 in T3, then T4->T1.
REQ-030 Reserved classes: exception with exc_code=2 in T3, then T4->T1.
REQ-031 unit_sel >= NUM_UNITS: no start pulse; treat as reserved (exc_code=2).
REQ-032 instr_done is asserted on every cycle whose next state is T1, except from T0 and TI.
REQ-033 The watchdog clears on entering T3; it saturates and never wraps.
REQ-034 Outputs not listed as active in a state are 0.

Reset
REQ-035 On rst: state=T0 and watchdog=0 immediately. All outputs are 0 except state.
REQ-036 Reset mid-instruction, including a T4 busy-wait, abandons the instruction. No unit_start, exception or instr_done is generated.
REQ-037 After rst deasserts, the first fetch_en occurs on the second rising edge (T0, then T1).

Configuration
REQ-038 Macro MCYC_IRQ_EN defined: irq is sampled on each instr_done cycle. If it is 1, the next state is TI instead of T1. TI asserts exception with exc_code=0 for one cycle, then goes to T1.
REQ-039 Interrupt vs. completing exception: a TIMEOUT or TRAP exception on the completing cycle takes priority; irq is re-sampled at the next boundary.
REQ-040 Macro MCYC_IRQ_EN undefined: no irq port, and TI is unreachable (decodes to T1).

Structure
REQ-041 Shared package mcyc_pkg holds the state localparams, class codes and exc_code values.
REQ-042 The watchdog is sub-module mcyc_watchdog, with inputs clk, rst, clr and inc, and output expired.

Verification
REQ-043 ALU after reset: state sequence 000,001,011,010,110,001; instr_done is high only in the 110 cycle.
REQ-044 BRANCH: with cond_ok=0, T3->T1 in 3 cycles total. With cond_ok=1, 5 cycles, and instr_done is in T5.
REQ-045 UNIT, unit_sel=2, unit_busy[2] high for 5 cycles after start: unit_start=4'b0100 for one cycle, stall is high for 5 cycles, and there is no exception.
REQ-046 UNIT, TIMEOUT_W=3, busy stuck at 1: exception with exc_code=3 on the 8th T4 cycle, then T1. A second run drops busy on that same cycle and sees no exception.
REQ-047 cls=6: exception with exc_code=2 in T3. With MCYC_IRQ_EN and irq=1 during an ALU: TI follows T4 with exc_code=0, then T1.
REQ-048 rst asserted in the 3rd T4 stall cycle: state=000 asynchronously, and no outputs pulse after release until T1.

Source files
------------

// File: rtl/mcyc_pkg.sv
// Shared encodings for the multi-cycle sequencer: state codes, instruction classes
// and exception codes. Optional interrupt support is enabled with MCYC_IRQ_EN.
package mcyc_pkg;

  localparam logic [2:0] ST_T0 = 3'b000;
  localparam logic [2:0] ST_T1 = 3'b001;
  localparam logic [2:0] ST_T2 = 3'b011;
  localparam logic [2:0] ST_T3 = 3'b010;
  localparam logic [2:0] ST_T4 = 3'b110;
  localparam logic [2:0] ST_T5 = 3'b111;
  localparam logic [2:0] ST_TI = 3'b100;

  localparam logic [2:0] CLS_SHORT  = 3'd0;
  localparam logic [2:0] CLS_ALU    = 3'd1;
  localparam logic [2:0] CLS_LOAD   = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_UNIT   = 3'd4;
  localparam logic [2:0] CLS_TRAP   = 3'd5;

  localparam logic [1:0] EXC_INT     = 2'd0;
  localparam logic [1:0] EXC_TRAP    = 2'd1;
  localparam logic [1:0] EXC_ILLEGAL = 2'd2;
  localparam logic [1:0] EXC_TIMEOUT = 2'd3;

  // A single unit still needs a one-bit select port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mcyc_watchdog.sv
// Saturating busy-wait counter for the sequencer; expired flags the all-ones count.
// Interrupt build option MCYC_IRQ_EN does not affect this block.
module mcyc_watchdog #(
  parameter int TIMEOUT_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [TIMEOUT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (clr)
      r_count <= '0;
    else if (inc && !expired)
      r_count <= r_count + TIMEOUT_W'(1);
  end

  assign expired = &r_count;

endmodule

// File: rtl/mcyc_sequencer.sv
// Multi-cycle instruction sequencer (T0..T5 plus interrupt state TI) with unit handshakes.
// Define MCYC_IRQ_EN to add the irq input and the TI interrupt-entry state.
module mcyc_sequencer
  import mcyc_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int TIMEOUT_W = 6,
  localparam int SEL_W = sel_width(NUM_UNITS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           cls,
  input  logic                 cond_ok,
  input  logic [SEL_W-1:0]     unit_sel,
  input  logic [NUM_UNITS-1:0] unit_busy,
`ifdef MCYC_IRQ_EN
  input  logic                 irq,
`endif
  output logic [2:0]           state,
  output logic                 fetch_en,
  output logic                 pc_inc,
  output logic [NUM_UNITS-1:0] unit_start,
  output logic                 stall,
  output logic                 exception,
  output logic [1:0]           exc_code,
  output logic                 instr_done
);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       w_wdClr;
  logic       w_wdInc;
  logic       w_expired;
  logic       w_unitValid;
  logic       w_busy;

  assign w_unitValid = (32'(unit_sel) < 32'(NUM_UNITS));
  assign w_busy      = w_unitValid && unit_busy[unit_sel];
  assign state       = r_state;

  mcyc_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_wdClr),
    .inc     (w_wdInc),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_T0;
    else
      r_state <= w_next;
  end

  // Next state and all strobes decode from the current state; instr_done marks completion.
  always_comb begin
    w_next     = ST_T1;
    fetch_en   = 1'b0;
    pc_inc     = 1'b0;
    unit_start = '0;
    stall      = 1'b0;
    exception  = 1'b0;
    exc_code   = EXC_INT;
    instr_done = 1'b0;
    w_wdClr    = 1'b0;
    w_wdInc    = 1'b0;
    case (r_state)
      ST_T0: w_next = ST_T1;
      ST_T1: begin
        fetch_en = 1'b1;
        w_next   = ST_T2;
      end
      ST_T2: begin
        pc_inc  = 1'b1;
        w_wdClr = 1'b1;
        w_next  = ST_T3;
      end
      ST_T3: begin
        case (cls)
          CLS_SHORT: instr_done = 1'b1;
          CLS_ALU, CLS_LOAD: w_next = ST_T4;
          CLS_BRANCH: begin
            if (cond_ok) w_next = ST_T4;
            else         instr_done = 1'b1;
          end
          CLS_UNIT: begin
            w_next = ST_T4;
            if (w_unitValid) begin
              unit_start[unit_sel] = 1'b1;
            end else begin
              exception = 1'b1;
              exc_code  = EXC_ILLEGAL;
            end
          end
          CLS_TRAP: begin
            w_next    = ST_T4;
            exception = 1'b1;
            exc_code  = EXC_TRAP;
          end
          default: begin
            w_next    = ST_T4;
            exception = 1'b1;
            exc_code  = EXC_ILLEGAL;
          end
        endcase
      end
      ST_T4: begin
        case (cls)
          CLS_LOAD, CLS_BRANCH: w_next = ST_T5;
          CLS_UNIT: begin
            if (w_busy) begin
              stall = 1'b1;
              if (w_expired) begin
                exception  = 1'b1;
                exc_code   = EXC_TIMEOUT;
                instr_done = 1'b1;
                w_wdClr    = 1'b1;
              end else begin
                w_next  = ST_T4;
                w_wdInc = 1'b1;
              end
            end else begin
              instr_done = 1'b1;
            end
          end
          default: instr_done = 1'b1;
        endcase
      end
      ST_T5: instr_done = 1'b1;
`ifdef MCYC_IRQ_EN
      ST_TI: begin
        exception = 1'b1;
        exc_code  = EXC_INT;
      end
`endif
      default: w_next = ST_T1;
    endcase
`ifdef MCYC_IRQ_EN
    // A completing-cycle exception outranks the interrupt; irq is retried next boundary.
    if (instr_done && irq && !exception)
      w_next = ST_TI;
`endif
  end

endmodule
